// File: rtl/booth_ctrl.sv
// booth_ctrl: control FSM for a radix-2 Booth multiplier (load, add/sub, arithmetic shift).
// Define BOOTH_CTRL_TIMEOUT_EN to add a busy-cycle timeout that forces DONE and sets a sticky err.
module booth_ctrl #(
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic Q0,
    input  logic Qm1,
    input  logic cnt_done,
    output logic busy,
    output logic done,
    output logic ldM,
    output logic ldQ,
    output logic clrA,
    output logic clrQm1,
    output logic addsub,
    output logic sub,
    output logic shift,
    output logic InitZcnt,
    output logic cnt,
    output logic err
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_ADDSUB, S_SHIFT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] stl_q, stl_d;
    logic          sub_q, sub_d;

`ifdef BOOTH_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          tmo_hit;

    // LOAD is busy cycle 1, so the cycle leaving LOAD loads 1; DONE lands on cycle TIMEOUT_CYCLES.
    assign tmo_hit = (state_q inside {S_SETTLE, S_CHECK, S_ADDSUB, S_SHIFT}) &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 2));

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == S_LOAD)
            tmo_d = TW'(1);
        else if (state_q != S_IDLE && state_q != S_DONE)
            tmo_d = tmo_q + TW'(1);
        if (state_q == S_IDLE && start)
            err_d = 1'b0;
        else if (tmo_hit)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stl_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stl_q   <= stl_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stl_d   = stl_q;
        sub_d   = sub_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_SETTLE;
                stl_d   = '0;
            end
            // Wait out the counter's registered flag so a stale cnt_done is never seen.
            S_SETTLE: begin
                if (stl_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CHECK;
                    stl_d   = '0;
                end else begin
                    stl_d = stl_q + SW'(1);
                end
            end
            S_CHECK: begin
                if (cnt_done) begin
                    state_d = S_DONE;
                end else begin
                    case ({Q0, Qm1})
                        2'b10: begin state_d = S_ADDSUB; sub_d = 1'b1; end
                        2'b01: begin state_d = S_ADDSUB; sub_d = 1'b0; end
                        default: state_d = S_SHIFT;
                    endcase
                end
            end
            S_ADDSUB: state_d = S_SHIFT;
            S_SHIFT:  state_d = S_SETTLE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
`ifdef BOOTH_CTRL_TIMEOUT_EN
        if (tmo_hit) state_d = S_DONE;
`endif
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        ldM      = 1'b0;
        ldQ      = 1'b0;
        clrA     = 1'b0;
        clrQm1   = 1'b0;
        addsub   = 1'b0;
        sub      = 1'b0;
        shift    = 1'b0;
        InitZcnt = 1'b0;
        cnt      = 1'b0;
        case (state_q)
            S_LOAD: begin
                ldM      = 1'b1;
                ldQ      = 1'b1;
                clrA     = 1'b1;
                clrQm1   = 1'b1;
                InitZcnt = 1'b1;
            end
            S_ADDSUB: begin
                addsub = 1'b1;
                sub    = sub_q;
            end
            S_SHIFT: begin
                shift = 1'b1;
                cnt   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Scoreboard bench for booth_ctrl: random Booth bit patterns against a closed-form latency/op model.
module tb_booth_ctrl;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst, start, Q0, Qm1, cnt_done;
    logic busy, done, ldM, ldQ, clrA, clrQm1, addsub, sub, shift, InitZcnt, cnt, err;

    booth_ctrl #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .Q0(Q0), .Qm1(Qm1), .cnt_done(cnt_done),
        .busy(busy), .done(done), .ldM(ldM), .ldQ(ldQ), .clrA(clrA), .clrQm1(clrQm1),
        .addsub(addsub), .sub(sub), .shift(shift), .InitZcnt(InitZcnt), .cnt(cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        int          dcyc;
        bit          tmo;
        int          nsub;
        logic [15:0] subs;
    } exp_t;

    exp_t       expq[$];
    int         vectors = 0, miscompares = 0;
    int         cur_n = 4;
    logic [1:0] pairs [16];
    bit         stuck = 1'b0;
    int         cnt_r;
    int         ops_done = 0, exp_ops = 0;
    bit         hold_chk = 1'b0;

    // Iteration counter with a registered done flag, as the datapath would have.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= 0;
            cnt_done <= 1'b0;
        end else if (InitZcnt) begin
            cnt_r    <= 0;
            cnt_done <= 1'b0;
        end else if (cnt) begin
            cnt_r    <= cnt_r + 1;
            cnt_done <= !stuck && (cnt_r + 1 == cur_n);
        end
    end

    assign {Q0, Qm1} = pairs[cnt_r[3:0]];

    task automatic chk(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(int n);
        exp_t e;
        e.n = n; e.tmo = 1'b0; e.nsub = 0; e.subs = '0;
        for (int i = 0; i < n; i++) begin
            if (pairs[i] == 2'b10) begin e.subs[e.nsub] = 1'b1; e.nsub++; end
            else if (pairs[i] == 2'b01) begin e.subs[e.nsub] = 1'b0; e.nsub++; end
        end
        e.dcyc = 3 * n + 4 + e.nsub;
        return e;
    endfunction

    // Monitor: traces each operation from LOAD to done and scores it against the queue head.
    initial begin
        bit          in_op = 1'b0, prev_is = 1'b0;
        int          cyc = 0, npulse = 0, nsub = 0, since_done = 100;
        logic [15:0] subs = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_op = 1'b0; prev_is = 1'b0;
            end else begin
                chk("cnt_eq_shift", int'(cnt), int'(shift));
                chk("init_with_cnt", int'(InitZcnt & cnt), 0);
                chk("sub_without_addsub", int'(sub & ~addsub), 0);
                if (ldM) begin
                    chk("load_after_start", int'(prev_is), 1);
                    chk("load_bundle", int'({ldQ, clrA, clrQm1, InitZcnt}), 15);
                    chk("err_clear_load", int'(err), 0);
                    if (hold_chk) chk("restart_gap", since_done, 2);
                    in_op = 1'b1; cyc = 1; npulse = 0; nsub = 0; subs = '0;
                end else if (in_op) begin
                    cyc++;
                    if (cnt) npulse++;
                    if (addsub) begin subs[nsub[3:0]] = sub; nsub++; end
                    if (done) begin
                        chk("busy_at_done", int'(busy), 1);
                        if (expq.size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            e = expq.pop_front();
                            chk("done_cycle", cyc, e.dcyc);
                            chk("err_at_done", int'(err), int'(e.tmo));
                            if (!e.tmo) begin
                                chk("cnt_pulses", npulse, e.n);
                                chk("addsub_count", nsub, e.nsub);
                                chk("sub_sequence", int'(subs), int'(e.subs));
                            end
                        end
                        in_op = 1'b0; since_done = 0;
                        ops_done++;
                    end
                end
                prev_is = !busy && start;
                since_done++;
            end
        end
    end

    task automatic wait_done(int target, int budget);
        for (int i = 0; i < budget && ops_done < target; i++) begin
            @(posedge clk); #2;
        end
        if (ops_done < target) chk("done_timeout", ops_done, target);
    endtask

    task automatic launch(int n, bit rnd);
        for (int b = 0; b < 200 && busy; b++) begin
            @(posedge clk); #2;
        end
        cur_n = n;
        if (rnd) for (int i = 0; i < 16; i++) pairs[i] = 2'($urandom_range(0, 3));
        expq.push_back(model(n));
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 16; i++) pairs[i] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({busy, done, ldM, ldQ, clrA, clrQm1, addsub, sub, shift,
                                   InitZcnt, cnt, err}), 0);
        rst = 1'b0;

        // N=4, all 00: done in cycle 16, no addsub
        launch(4, 1'b0); exp_ops++; wait_done(exp_ops, 200);

        // N=4, pairs 10,01,00,11: subtract, add, two plain shifts, done in cycle 18
        pairs[0] = 2'b10; pairs[1] = 2'b01; pairs[2] = 2'b00; pairs[3] = 2'b11;
        launch(4, 1'b0); exp_ops++; wait_done(exp_ops, 200);

        // Stale cnt_done from the previous op must not cut the next one short
        chk("stale_flag_present", int'(cnt_done), 1);
        launch(4, 1'b1); exp_ops++; wait_done(exp_ops, 200);

        for (int r = 0; r < 12; r++) begin
            launch($urandom_range(1, 8), 1'b1); exp_ops++; wait_done(exp_ops, 200);
        end

        // start held high across two ops: no restart while busy, LOAD two cycles after done
        cur_n = 3;
        for (int i = 0; i < 16; i++) pairs[i] = 2'($urandom_range(0, 3));
        expq.push_back(model(3));
        start = 1'b1;
        exp_ops++; wait_done(exp_ops, 200);
        cur_n = 5;
        for (int i = 0; i < 16; i++) pairs[i] = 2'($urandom_range(0, 3));
        expq.push_back(model(5));
        hold_chk = 1'b1;
        exp_ops++; wait_done(exp_ops, 200);
        start = 1'b0; hold_chk = 1'b0;

        // cnt_done stuck low
        stuck = 1'b1; cur_n = 4;
`ifdef BOOTH_CTRL_TIMEOUT_EN
        begin
            exp_t e;
            e.n = 4; e.dcyc = TMO; e.tmo = 1'b1; e.nsub = 0; e.subs = '0;
            expq.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        exp_ops++; wait_done(exp_ops, 200);
        chk("err_sticky_idle", int'(err), 1);
        stuck = 1'b0;
        launch(4, 1'b1); exp_ops++; wait_done(exp_ops, 200);
`else
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("busy_forever", int'(busy), 1);
        chk("err_tied_low", int'(err), 0);
        #1 rst = 1'b1;
        #1;
        chk("reset_stuck_outputs", int'({busy, done, ldM, ldQ, clrA, clrQm1, addsub, sub, shift,
                                         InitZcnt, cnt, err}), 0);
        expq.delete();
        @(posedge clk); #1 rst = 1'b0;
        stuck = 1'b0;
`endif

        // Asynchronous reset in the middle of an op aborts immediately
        launch(6, 1'b1);
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("reset_midrun_outputs", int'({busy, done, ldM, ldQ, clrA, clrQm1, addsub, sub, shift,
                                          InitZcnt, cnt, err}), 0);
        expq.delete();
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("idle_after_reset", int'(busy), 0);
        launch(4, 1'b1); exp_ops++; wait_done(exp_ops, 200);

        repeat (3) @(posedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
